// File: rtl/exec_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : exec_stage_if
// Brief    : Operand/control, writeback and data-memory bundle for exec_stage.
// Revision : 1.0
// ============================================================================
interface exec_stage_if;
    logic        Valid_in;
    logic [31:0] Q1;
    logic [31:0] Q2;
    logic        We_in;
    logic [1:0]  AluOp_in;
    logic        Demux_in;
    logic        EN;
    logic        Wb_valid;
    logic        Wb_we;
    logic [31:0] Wb_data;
    logic        Mem_req;
    logic        Mem_we;
    logic [31:0] Mem_addr;
    logic [31:0] Mem_wdata;
    logic        Mem_ack;
    logic        Zero;
    logic        Err;

    modport master (
        output Valid_in, Q1, Q2, We_in, AluOp_in, Demux_in, Mem_ack,
        input  EN, Wb_valid, Wb_we, Wb_data, Mem_req, Mem_we, Mem_addr,
               Mem_wdata, Zero, Err
    );

    modport slave (
        input  Valid_in, Q1, Q2, We_in, AluOp_in, Demux_in, Mem_ack,
        output EN, Wb_valid, Wb_we, Wb_data, Mem_req, Mem_we, Mem_addr,
               Mem_wdata, Zero, Err
    );
endinterface
`default_nettype wire

// File: rtl/exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : exec_stage
// Brief    : Execute stage: ALU, then register writeback or memory req/ack.
//            Optional memory-ack timeout enabled by macro EXEC_MEM_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module exec_stage #(
    parameter int TIMEOUT = 16
) (
    input  wire          clk,
    input  wire          rst_n,
    exec_stage_if.slave  bus
);
    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_WB   = 2'd1;
    localparam logic [1:0] c_S_MEM  = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic [31:0] r_res;
    logic [31:0] r_st;
    logic        r_we;
    logic        r_zero;
    logic        r_err;
    logic [31:0] w_alu;
    logic        w_en;
    logic        w_accept;
    logic        w_timeout;

    assign w_en     = rst_n & (r_state != c_S_MEM);
    assign w_accept = w_en & bus.Valid_in;

    always_comb begin
        w_alu = 32'd0;
        case (bus.AluOp_in)
            2'b00:   w_alu = bus.Q1 + bus.Q2;
            2'b01:   w_alu = bus.Q1 - bus.Q2;
            2'b10:   w_alu = bus.Q1 & bus.Q2;
            default: w_alu = bus.Q1 | bus.Q2;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_res  <= 32'd0;
            r_st   <= 32'd0;
            r_we   <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_accept) begin
            r_res  <= w_alu;
            r_st   <= bus.Q2;
            r_we   <= bus.We_in;
            r_zero <= (w_alu == 32'd0);
        end
    end

`ifdef EXEC_MEM_TIMEOUT_EN
    localparam logic [7:0] c_TMO_LIM = 8'(TIMEOUT - 1);

    logic [7:0] r_tmo_cnt;

    // Held at zero outside MEM_WAIT, so it always starts from zero on entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tmo_cnt <= 8'd0;
        end else if (r_state != c_S_MEM) begin
            r_tmo_cnt <= 8'd0;
        end else if (!bus.Mem_ack) begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
        end
    end

    assign w_timeout = (r_state == c_S_MEM) && !bus.Mem_ack && (r_tmo_cnt == c_TMO_LIM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end
`else
    wire [7:0] w_unused_timeout = 8'(TIMEOUT);

    assign w_timeout = 1'b0;

    always_ff @(posedge clk) begin
        r_err <= 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_S_IDLE, c_S_WB: begin
                if (w_accept) begin
                    w_next = bus.Demux_in ? c_S_MEM : c_S_WB;
                end else begin
                    w_next = c_S_IDLE;
                end
            end
            c_S_MEM: begin
                // Ack beats a simultaneous timeout.
                if (bus.Mem_ack || w_timeout) begin
                    w_next = c_S_IDLE;
                end
            end
            default: w_next = c_S_IDLE;
        endcase
    end

    always_comb begin
        bus.EN       = w_en;
        bus.Wb_valid = 1'b0;
        bus.Wb_we    = 1'b0;
        bus.Mem_req  = 1'b0;
        bus.Mem_we   = 1'b0;
        case (r_state)
            c_S_WB: begin
                bus.Wb_valid = 1'b1;
                bus.Wb_we    = r_we;
            end
            c_S_MEM: begin
                bus.Mem_req = 1'b1;
                bus.Mem_we  = r_we;
            end
            default: ;
        endcase
    end

    assign bus.Wb_data   = r_res;
    assign bus.Mem_addr  = r_res;
    assign bus.Mem_wdata = r_st;
    assign bus.Zero      = r_zero;
    assign bus.Err       = r_err;
endmodule
`default_nettype wire

// File: doc/exec_stage.md
# exec_stage

Execute-stage consumer sitting directly downstream of the ID/EX pipeline buffer. It takes the buffered operands and control (`Q1`, `Q2`, `We`, `AluOp`, `Demux`), performs the ALU operation, and routes the result either to the register-file writeback port or to the data-memory port through a req/ack handshake. It drives the `EN` line that freezes the upstream buffer while a memory transaction is outstanding.

## Interface
- `TIMEOUT`, 16: memory-ack timeout in cycles. Used only when `EXEC_MEM_TIMEOUT_EN` is defined; legal range 2..255.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `Valid_in`  in  1  upstream buffer holds a valid instruction.
- `Q1`, `Q2`  in  32  operands A and B.
- `We_in`  in  1  write enable for the destination.
- `AluOp_in`  in  2  ALU operation select.
- `Demux_in`  in  1  destination select: 0 = register writeback, 1 = memory.
- `EN`  out  1  upstream enable / ready.
- `Wb_valid`  out  1  one-cycle writeback strobe.
- `Wb_we`  out  1  register write enable.
- `Wb_data`  out  32  writeback value.
- `Mem_req`  out  1  memory request, level.
- `Mem_we`  out  1  memory write enable.
- `Mem_addr`  out  32  memory address (ALU result).
- `Mem_wdata`  out  32  store data (`Q2`).
- `Mem_ack`  in  1  memory completion, one-cycle pulse.
- `Zero`  out  1  registered: last ALU result == 0.
- `Err`  out  1  sticky timeout flag.

## Operation
- ALU, mod 2^32, no carry out:
  - `AluOp` 00 = `Q1+Q2`
  - 01 = `Q1-Q2`
  - 10 = `Q1&Q2`
  - 11 = `Q1|Q2`
- FSM states: IDLE, WB, MEM_WAIT.
- Accept condition: `EN & Valid_in`. On accept:
  - register result into `Res_q`, `Q2` into `St_q`, `We_in` into `We_q`.
  - update `Zero`.
  - next state is WB if `Demux_in=0`, MEM_WAIT if `Demux_in=1`.
- No accept in IDLE or WB: next state is IDLE.
- IDLE:
  - `EN=1`.
  - all strobes 0.
- WB:
  - `Wb_valid=1`, `Wb_data=Res_q`, `Wb_we=We_q`.
  - `EN=1`, so back-to-back accepts are allowed.
- MEM_WAIT:
  - `EN=0`.
  - `Mem_req=1`, `Mem_addr=Res_q`, `Mem_wdata=St_q`, `Mem_we=We_q`.
  - `Mem_ack=1` moves to IDLE; `Mem_req` is 0 the following cycle.
- `Valid_in` while `EN=0` is ignored; upstream holds its contents because `EN` is low.
- `Mem_ack` outside MEM_WAIT is ignored and produces no state change.
- `Wb_data`, `Mem_addr`, `Mem_wdata` hold their last values when not strobed. Only the strobes qualify them.

## Timing
- Reset (`rst_n=0` at a rising edge):
  - state IDLE.
  - `Res_q`, `St_q`, `We_q`, `Zero`, `Err`, timeout counter all 0.
- `EN` = `rst_n & (state != MEM_WAIT)`, so it is 0 while `rst_n` is low.
- All other outputs are decoded from registered state and are 0 after reset.
- Writeback latency: accept at edge N, then `Wb_valid` is high in cycle N+1. Throughput is 1 per cycle.
- Memory path:
  - accept at edge N; `Mem_req` rises in cycle N+1.
  - `Mem_ack` may arrive in that same cycle, giving a 1-cycle request.
  - `EN` returns high in the cycle after the ack edge.
- Reset during MEM_WAIT:
  - transaction is abandoned.
  - `Mem_req` drops after that edge.
  - no writeback occurs.

## Configuration
- `EXEC_MEM_TIMEOUT_EN` defined:
  - an 8-bit counter clears on entry to MEM_WAIT and increments each cycle in MEM_WAIT without ack.
  - if the counter reaches `TIMEOUT-1` with `Mem_ack=0`: next state IDLE, `Mem_req` drops, `Err` is set to 1.
  - `Err` stays 1 until reset; later instructions still execute.
  - an ack in the same cycle as the limit wins: normal completion, no `Err`.
- Undefined:
  - MEM_WAIT waits indefinitely.
  - counter is absent and `Err` is tied to 0.

## Test plan
- Reset: hold `rst_n=0` for 2 cycles with `Valid_in=1` -> all outputs 0, `EN=0`. After release, `EN=1`.
- Writeback: `Q1=5`, `Q2=7`, `AluOp=00`, `Demux=0`, `We=1` -> next cycle `Wb_valid=1`, `Wb_data=12`, `Wb_we=1`, `Zero=0`.
- Back-to-back writebacks:
  - instruction 1: SUB `Q1=3`, `Q2=3`.
  - instruction 2: OR `Q1=0xF0`, `Q2=0x0F`.
  - required: consecutive `Wb_data` of 0 (`Zero=1`) then 0xFF (`Zero=0`), `EN` never low.
- Wrap and memory path: ADD `Q1=0xFFFFFFFF`, `Q2=2`, `Demux=1`, ack after 3 cycles:
  - `Mem_addr=1`, `Mem_wdata=2`.
  - `Mem_req` high for 3 cycles, `EN=0` for those cycles, then 1.
  - `Valid_in` pulses during the stall are ignored.
- Reset mid-transaction: assert `rst_n=0` in cycle 2 of MEM_WAIT -> `Mem_req=0` next cycle, no `Wb_valid`, `EN=1` after release.
- With `EXEC_MEM_TIMEOUT_EN`, `TIMEOUT=4`, no ack -> `Mem_req` high exactly 4 cycles, then `Err=1` and IDLE. A following writeback instruction still produces `Wb_valid`, and `Err` stays 1.
